// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the RUN-state priority rules for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

  // Branch squash beats load-use and jump: the ID instruction is discarded anyway.
  function automatic stage_ctrl_t run_rules(input logic branch_taken,
                                            input logic load_use,
                                            input logic jump);
    stage_ctrl_t c;
    c = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
          if_id_flush: 1'b0, id_ex_flush: 1'b0};
    if (branch_taken) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end else if (jump) begin
      c.if_id_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes for the 5-stage MIPS datapath,
// covering reset drain, load-use stalls, jump/branch squashes and data-memory waits.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             jump_id,
  input  logic             branch_taken_ex,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_error
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_e       state_q, state_d;
  logic [INIT_W-1:0] init_q, init_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_error_q, mem_error_d;
  stage_ctrl_t       ctrl;
  logic              load_use;
  logic              stall_inc, flush_inc;

  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

  always_comb begin
    state_d     = state_q;
    init_d      = init_q;
    wait_d      = wait_q;
    mem_error_d = mem_error_q;
    ctrl        = '0;
    case (state_q)
      ST_INIT: begin
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
        if (init_q == INIT_LAST) state_d = ST_RUN;
        else                     init_d  = init_q + INIT_W'(1);
      end
      ST_RUN: begin
        if (dmem_busy) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          ctrl = run_rules(branch_taken_ex, load_use, jump_id);
        end
      end
      ST_MEM_WAIT: begin
        // Everything stays frozen while busy; hazards are re-presented after release.
        if (dmem_busy) begin
          if (wait_q == WAIT_MAX) mem_error_d = 1'b1;
          else                    wait_d      = wait_q + WAIT_W'(1);
        end else begin
          ctrl    = run_rules(branch_taken_ex, load_use, jump_id);
          state_d = ST_RUN;
          wait_d  = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_q      <= '0;
      wait_q      <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      wait_q      <= wait_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign stall_inc = (state_q != ST_INIT) && !ctrl.pc_en;
  assign flush_inc = (state_q != ST_INIT) && ctrl.if_id_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock  (clock),
    .reset  (reset),
    .inc_i  (stall_inc),
    .count_o(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock  (clock),
    .reset  (reset),
    .inc_i  (flush_inc),
    .count_o(flush_cnt)
  );

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign ctrl_state  = state_q;
  assign mem_error   = mem_error_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath.
- Generates the per-stage write enables and flush (bubble) strobes for PC, IF/ID, ID/EX and EX/MEM.
- Handles the post-reset pipeline drain, load-use stalls, jump and taken-branch squashes, and multi-cycle data-memory waits.
- Keeps saturating stall/flush statistics and a sticky memory-timeout flag for the VGA debug display.

Parameters:
- INIT_CYCLES, 4: cycles spent in INIT draining the pipeline after reset (min 1).
- MEM_TIMEOUT, 255: consecutive MEM_WAIT cycles with dmem_busy=1 before mem_error sets.
- CNT_W, 16: width of the statistics counters.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  instruction in EX is a load (ID/EX mem-to-reg select).
- ex_rt  in  5  destination register (rt) of the instruction in EX.
- jump_id  in  1  j/jal/jr resolved in ID this cycle.
- branch_taken_ex  in  1  branch resolved taken in EX this cycle.
- dmem_busy  in  1  data memory not ready; access in MEM must hold.
- pc_en  out  1  PC register write enable.
- if_id_en  out  1  IF/ID write enable.
- id_ex_en  out  1  ID/EX write enable.
- ex_mem_en  out  1  EX/MEM write enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  zero ID/EX control fields (reg_write, mem_write, jal).
- ctrl_state  out  2  0=INIT, 1=RUN, 2=MEM_WAIT.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 outside INIT.
- flush_cnt  out  CNT_W  saturating count of cycles with if_id_flush=1 outside INIT.
- mem_error  out  1  sticky memory-timeout flag.

Behaviour:
- Registered: state, init counter, wait counter, stall_cnt, flush_cnt, mem_error. All enable and flush outputs are combinational from the current state and inputs, so they act in the same cycle.
- Reset (clock edge with reset=1) sets: state=INIT, init counter=0, wait counter=0, both stat counters=0, mem_error=0.
- INIT: all four enables=0; if_id_flush=1, id_ex_flush=1. Stays exactly INIT_CYCLES cycles, then goes to RUN. All inputs are ignored.
- RUN: evaluate in priority order; the first matching rule applies:
  1. dmem_busy=1: all four enables=0, flushes=0. Next state MEM_WAIT, wait counter=1.
  2. branch_taken_ex=1: all enables=1, if_id_flush=1, id_ex_flush=1. This overrides load-use and jump, since the ID instruction is squashed anyway.
  3. Load-use: ex_mem_read=1 and ex_rt!=0 and ((id_uses_rs and id_rs==ex_rt) or (id_uses_rt and id_rt==ex_rt)). Then pc_en=0, if_id_en=0, id_ex_en=1, ex_mem_en=1, id_ex_flush=1, if_id_flush=0. This gives exactly one bubble per hazard.
  4. jump_id=1: all enables=1, if_id_flush=1, id_ex_flush=0.
  5. Otherwise: all enables=1, flushes=0.
- MEM_WAIT:
  - While dmem_busy=1: all enables=0, flushes=0, wait counter increments, saturating at MEM_TIMEOUT.
  - When the wait counter equals MEM_TIMEOUT and dmem_busy=1: mem_error<=1. Remain in MEM_WAIT; there is no recovery without reset.
  - When dmem_busy=0: outputs follow RUN rules 2–5 in the same cycle, next state RUN, wait counter cleared.
- Hazards or branches arriving during a hold are not acted on. The frozen stages re-present them after release.
- stall_cnt increments in any non-INIT cycle with pc_en=0. flush_cnt increments in any non-INIT cycle with if_id_flush=1. Both saturate at all-ones and do not wrap.
- Reset mid-MEM_WAIT or mid-stall returns to INIT immediately, with the counters and mem_error cleared.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encodings ST_INIT, ST_RUN, ST_MEM_WAIT;
  - REG_ZERO=5'd0.
- Sub-module sat_counter (width CNT_W, increment strobe, synchronous clear), instantiated twice for stall_cnt and flush_cnt.
- The hazard compare stays inline.

Test Plan:
- INIT_CYCLES=4; release reset -> pc_en=0 and both flushes=1 for exactly 4 cycles, ctrl_state=0; then ctrl_state=1, all enables=1, stall_cnt=0.
- Load-use with ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cnt=1. Same stimulus with ex_rt=0 -> no stall.
- Load-use hazard plus branch_taken_ex=1 in the same cycle -> pc_en=1, both flushes=1, stall_cnt unchanged, flush_cnt+1. jump_id alone -> if_id_flush=1, id_ex_flush=0.
- dmem_busy=1 for 3 cycles -> all enables=0 for 3 cycles, ctrl_state=2 after the first; dmem_busy=0 -> enables=1 that cycle, ctrl_state=1 next; stall_cnt=3.
- MEM_TIMEOUT=5, dmem_busy held at 1 -> mem_error=1 after the 5th MEM_WAIT cycle and stays 1 after busy drops; reset -> mem_error=0, ctrl_state=0.
- Force 65536 load-use stalls -> stall_cnt=16'hFFFF and holds, no wrap to 0.
